// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit FIFO slice.
//   uart_tx_state_e : launch controller states (IDLE, LAUNCH, WAIT_BUSY,
//                     WAIT_DONE)
//   BUSY_TIMEOUT    : cycles the controller waits for the transmitter to
//                     raise tx_busy before it treats the word as consumed
//   OVF_COUNT_WIDTH : width of the optional dropped-write counter
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_tx_state_e;

  localparam int BUSY_TIMEOUT    = 2;
  localparam int OVF_COUNT_WIDTH = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Storage array, read/write pointers, entry count and registered status flags
// for the UART transmit FIFO.
// Parameters:
//   DATA_WIDTH : word width
//   DEPTH      : number of entries (power of two, >= 2)
//   ADDR_WIDTH : pointer width, derived from DEPTH
// Ports:
//   clk        : clock, all state on rising edge
//   reset_n    : synchronous active-low reset
//   push       : write request (ignored while full or in reset)
//   pop        : read request (ignored while empty)
//   wr_data    : word to store on an accepted push
//   rd_data    : word at the head of the queue
//   full       : registered, fill_level == DEPTH
//   empty      : registered, fill_level == 0
//   fill_level : current number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  // Requests are qualified here so the array and pointers can never be
  // corrupted by a push into a full queue, a pop from an empty one, or a
  // write that arrives while reset is asserted.
  assign do_push = push && !full && reset_n;
  assign do_pop  = pop && !empty;

  // A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers are exactly ADDR_WIDTH bits and DEPTH is a power of two, so
  // incrementing past DEPTH-1 wraps to 0 on its own. Flags are computed from
  // the next count so they are registered yet line up with fill_level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_LEVEL);
      empty <= (count_next == '0);
    end
  end

  // The array itself is not reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data    = mem[rd_ptr];
  assign fill_level = count;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffers producer words and hands them one at a time to a UART transmitter
// using a launch pulse and the transmitter's busy flag.
// Optional feature macro: UART_TX_OVF_COUNT_EN adds the ovf_count output, a
// saturating count of dropped writes.
// Parameters:
//   DATA_WIDTH : word width
//   DEPTH      : FIFO entries (power of two, >= 2)
//   ADDR_WIDTH : pointer width, derived from DEPTH (do not override)
// Ports:
//   clk              : clock, all state on rising edge
//   reset_n          : synchronous active-low reset
//   wr_en            : producer write strobe
//   wr_data          : producer word
//   tx_busy          : busy flag from the transmitter
//   tx_data_valid    : one-cycle launch pulse to the transmitter
//   tx_parallel_data : word presented to the transmitter, held between pops
//   full, empty      : registered FIFO status
//   fill_level       : number of queued words, 0..DEPTH
//   overflow         : one-cycle pulse after each dropped write
//   ovf_count        : (UART_TX_OVF_COUNT_EN only) saturating dropped-write count
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tx_busy,
  output logic                  tx_data_valid,
  output logic [DATA_WIDTH-1:0] tx_parallel_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow
`ifdef UART_TX_OVF_COUNT_EN
  ,
  output logic [OVF_COUNT_WIDTH-1:0] ovf_count
`endif
);

  localparam logic [1:0] BUSY_CNT_LAST = 2'(BUSY_TIMEOUT - 1);

  uart_tx_state_e        state;
  logic [1:0]            busy_cnt;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;

  // A word is taken only from IDLE with the transmitter idle; the head word
  // is latched into tx_parallel_data on that same edge.
  assign pop           = (state == IDLE) && !empty && !tx_busy;
  assign tx_data_valid = (state == LAUNCH);

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (wr_en),
    .pop        (pop),
    .wr_data    (wr_data),
    .rd_data    (head_data),
    .full       (full),
    .empty      (empty),
    .fill_level (fill_level)
  );

  // Launch controller. After the one-cycle LAUNCH pulse it waits for the
  // transmitter to acknowledge with tx_busy; if that never comes within
  // BUSY_TIMEOUT cycles the word is considered sent so the queue cannot
  // stall. The IDLE->LAUNCH->WAIT_BUSY(x2)->IDLE path gives the 4-cycle
  // minimum spacing between launch pulses.
  // The overflow pulse uses the registered full flag, so a write is dropped
  // even when a pop frees an entry on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      busy_cnt         <= '0;
      tx_parallel_data <= '0;
      overflow         <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (pop) tx_parallel_data <= head_data;
      unique case (state)
        IDLE: begin
          if (pop) state <= LAUNCH;
        end
        LAUNCH: begin
          state    <= WAIT_BUSY;
          busy_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == BUSY_CNT_LAST) begin
            state <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_OVF_COUNT_EN
  // Dropped-write counter; it sticks at its maximum rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (wr_en && full && (ovf_count != {OVF_COUNT_WIDTH{1'b1}})) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed self-checking bench for uart_tx_fifo (default parameters).
// Build with UART_TX_OVF_COUNT_EN defined to also check ovf_count.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_busy;
  logic       tx_data_valid;
  logic [7:0] tx_parallel_data;
  logic       full;
  logic       empty;
  logic [4:0] fill_level;
  logic       overflow;
`ifdef UART_TX_OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  int last_valid_cycle = -100;
  int min_gap = 1000;
  int busy_violations = 0;
  int busy_left = 0;
  bit pending_busy = 1'b0;
  int valid_seen;
  logic [7:0] rx_q [$];

  uart_tx_fifo dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .tx_busy          (tx_busy),
    .tx_data_valid    (tx_data_valid),
    .tx_parallel_data (tx_parallel_data),
    .full             (full),
    .empty            (empty),
    .fill_level       (fill_level),
`ifdef UART_TX_OVF_COUNT_EN
    .ovf_count        (ovf_count),
`endif
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  // Drive the producer/transmitter inputs, then advance one clock.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic busy);
    wr_en   = w;
    wr_data = d;
    tx_busy = busy;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Transmitter model: tx_busy rises one cycle after a launch pulse and stays
  // high for 10 cycles. Returns once rx_q holds target words and the
  // transmitter has gone busy for the last of them (tx_busy left high).
  task automatic runDrain(input int target);
    int cyc = 0;
    while (!(rx_q.size() >= target && busy_left > 0) && cyc < 1000) begin
      step();
      cyc++;
      if (tx_data_valid === 1'b1) begin
        if (tx_busy) busy_violations++;
        if (cycle_no - last_valid_cycle < min_gap) min_gap = cycle_no - last_valid_cycle;
        last_valid_cycle = cycle_no;
        rx_q.push_back(tx_parallel_data);
        pending_busy = 1'b1;
      end else if (pending_busy) begin
        pending_busy = 1'b0;
        tx_busy      = 1'b1;
        busy_left    = 10;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
    checkOutput("drain_complete", 32'(rx_q.size() >= target), 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    reset_n = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h33;
    tx_busy = 1'b0;

    // Reset with a write strobe held high: the write must be ignored.
    step(); step(); step();
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_fill", fill_level, 5'd0);
    checkOutput("rst_valid", tx_data_valid, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_data", tx_parallel_data, 8'h00);
`ifdef UART_TX_OVF_COUNT_EN
    checkOutput("rst_ovf_count", ovf_count, 8'd0);
`endif
    wr_en   = 1'b0;
    reset_n = 1'b1;
    step();
    checkOutput("rst_write_ignored", fill_level, 5'd0);

    // Single word with an idle transmitter.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    wr_en = 1'b0;
    checkOutput("single_fill", fill_level, 5'd1);
    checkOutput("single_valid_early", tx_data_valid, 1'b0);
    step();
    checkOutput("single_valid", tx_data_valid, 1'b1);
    checkOutput("single_data", tx_parallel_data, 8'hA5);
    checkOutput("single_empty", empty, 1'b1);
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tx_data_valid === 1'b1) valid_seen++;
    end
    checkOutput("single_one_pulse", valid_seen, 0);
    checkOutput("single_data_hold", tx_parallel_data, 8'hA5);

    // Fill all 16 entries while the transmitter is busy.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    checkOutput("fill_full", full, 1'b1);
    checkOutput("fill_level16", fill_level, 5'd16);
    checkOutput("fill_no_ovf", overflow, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("ovf_pulse", overflow, 1'b1);
    checkOutput("ovf_fill", fill_level, 5'd16);
`ifdef UART_TX_OVF_COUNT_EN
    checkOutput("ovf_count1", ovf_count, 8'd1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_one_cycle", overflow, 1'b0);

    // Write while full on the same edge as a pop: still dropped.
    applyStimulus(1'b1, 8'hDD, 1'b0);
    wr_en = 1'b0;
    checkOutput("pop_ovf_pulse", overflow, 1'b1);
    checkOutput("pop_ovf_fill", fill_level, 5'd15);
    checkOutput("pop_ovf_valid", tx_data_valid, 1'b1);
    checkOutput("pop_ovf_data", tx_parallel_data, 8'h00);
`ifdef UART_TX_OVF_COUNT_EN
    checkOutput("ovf_count2", ovf_count, 8'd2);
`endif
    rx_q.push_back(tx_parallel_data);
    last_valid_cycle = cycle_no;
    pending_busy     = 1'b1;
    busy_left        = 0;
    runDrain(16);
    tx_busy   = 1'b0;
    busy_left = 0;
    step(); step(); step();
    for (int i = 0; i < 16; i++)
      checkOutput("drain_order", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(i));
    checkOutput("drain_empty", empty, 1'b1);
    checkOutput("drain_fill", fill_level, 5'd0);

    // Wrap-around: fill 16, drain 8, add 8, drain the rest.
    rx_q.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1);
    wr_en = 1'b0;
    checkOutput("wrap_full", full, 1'b1);
    tx_busy   = 1'b0;
    busy_left = 0;
    runDrain(8);
    checkOutput("wrap_fill8", fill_level, 5'd8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b1);
    wr_en = 1'b0;
    checkOutput("wrap_refull", full, 1'b1);
    tx_busy   = 1'b0;
    busy_left = 0;
    runDrain(24);
    tx_busy   = 1'b0;
    busy_left = 0;
    step(); step(); step();
    for (int i = 0; i < 24; i++)
      checkOutput("wrap_order", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'h10 + 32'(i));
    checkOutput("wrap_empty", empty, 1'b1);
    checkOutput("busy_violations", busy_violations, 0);
    checkOutput("min_gap_ok", 32'(min_gap >= 4), 32'd1);

    // Transmitter never raises busy: timeout returns to IDLE and the next
    // word launches 4 cycles after the first. The second write lands on the
    // pop edge, so the level stays at 1.
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("to_fill1", fill_level, 5'd1);
    applyStimulus(1'b1, 8'h66, 1'b0);
    wr_en = 1'b0;
    checkOutput("to_wr_pop_fill", fill_level, 5'd1);
    checkOutput("to_valid1", tx_data_valid, 1'b1);
    checkOutput("to_data1", tx_parallel_data, 8'h55);
    step();
    checkOutput("to_gap1", tx_data_valid, 1'b0);
    step();
    checkOutput("to_gap2", tx_data_valid, 1'b0);
    step();
    checkOutput("to_gap3", tx_data_valid, 1'b0);
    step();
    checkOutput("to_valid2", tx_data_valid, 1'b1);
    checkOutput("to_data2", tx_parallel_data, 8'h66);
    checkOutput("to_empty", empty, 1'b1);
    step(); step(); step(); step();

    // Reset while in WAIT_DONE with 5 words still queued.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h70 + 8'(i), 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("mid_valid", tx_data_valid, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid_fill5", fill_level, 5'd5);
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid_rst_fill", fill_level, 5'd0);
    checkOutput("mid_rst_empty", empty, 1'b1);
    checkOutput("mid_rst_data", tx_parallel_data, 8'h00);
    reset_n = 1'b1;
    tx_busy = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_data_valid === 1'b1) valid_seen++;
    end
    checkOutput("mid_no_valid", valid_seen, 0);
    checkOutput("mid_empty_after", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the written and transmitted data words.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of FIFO entries and SHALL be a power of two of at least 2.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), SHALL set the pointer width and SHALL not be overridden.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 wr_en  input  1  SHALL be the producer write strobe, sampled each cycle.
REQ-007 wr_data  input  DATA_WIDTH  SHALL be the producer data, captured when wr_en=1 and the write is accepted.
REQ-008 tx_busy  input  1  SHALL be the busy flag from the downstream uart transmitter.
REQ-009 tx_data_valid  output  1  SHALL be the one-cycle launch pulse to the transmitter.
REQ-010 tx_parallel_data  output  DATA_WIDTH  SHALL be the word presented to the transmitter.
REQ-011 full, empty  output  1 each  SHALL be the registered FIFO status flags.
REQ-012 fill_level  output  ADDR_WIDTH+1  SHALL be the current entry count, 0..DEPTH.
REQ-013 overflow  output  1  SHALL pulse for one cycle for each dropped write.

Function
REQ-014 A write SHALL be accepted when wr_en=1 and full=0, storing wr_data and incrementing fill_level.
REQ-015 A write with full=1 SHALL be dropped and SHALL assert overflow on the next cycle, even if a pop occurs in the same cycle.
REQ-016 The controller FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE -> LAUNCH SHALL occur when empty=0 and tx_busy=0; in that cycle the head word SHALL be popped into the tx_parallel_data register.
REQ-018 In LAUNCH, tx_data_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT_BUSY.
REQ-019 WAIT_BUSY -> WAIT_DONE SHALL occur when tx_busy=1; if tx_busy stays 0 for 2 cycles, the FSM SHALL return to IDLE and treat the word as consumed.
REQ-020 WAIT_DONE -> IDLE SHALL occur when tx_busy=0.
REQ-021 tx_parallel_data SHALL hold its value from the pop until the next pop.
REQ-022 A simultaneous accepted write and pop SHALL leave fill_level unchanged.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 empty SHALL equal (fill_level==0) and full SHALL equal (fill_level==DEPTH).
REQ-025 The minimum spacing between tx_data_valid pulses SHALL be 4 cycles.

Reset
REQ-026 While reset_n=0 at a clock edge: FSM SHALL go to IDLE; pointers and fill_level SHALL be 0; empty=1; full=0; tx_data_valid=0; overflow=0; tx_parallel_data=0.
REQ-027 Reset mid-transfer SHALL discard all FIFO contents with no further tx_data_valid pulse.
REQ-028 Writes presented during reset SHALL be ignored.

Configuration
REQ-029 Macro UART_TX_OVF_COUNT_EN, when defined, SHALL add the output ovf_count (8 bits), which counts dropped writes, saturates at 255 and is reset to 0.
REQ-030 Without UART_TX_OVF_COUNT_EN, the ovf_count port and its logic SHALL be absent, and the overflow pulse SHALL be unchanged.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE) and the constant BUSY_TIMEOUT=2.
REQ-032 Storage and pointers SHALL sit in one sub-module, uart_fifo_mem; the FSM SHALL sit in the top module.

Verification
REQ-033 Reset, then write 0xA5 with tx_busy held 0 -> tx_data_valid pulses once within 2 cycles with tx_parallel_data=0xA5, and empty=1 afterwards.
REQ-034 Write 16 words 0x00..0x0F back to back with tx_busy=1 -> full=1 and fill_level=16; a 17th write -> overflow pulse, and ovf_count=1 if UART_TX_OVF_COUNT_EN is defined.
REQ-035 Drain with a transmitter model (busy high 1 cycle after valid, for 10 cycles) -> words leave in order 0x00..0x0F, with no valid pulse while tx_busy=1.
REQ-036 Fill 16 words, drain 8, write 8 more -> output order is preserved across pointer wrap-around.
REQ-037 Pulse tx_data_valid while tx_busy stays 0 -> FSM returns to IDLE after 2 cycles and launches the next word.
REQ-038 Assert reset_n=0 during WAIT_DONE with 5 entries queued -> fill_level=0 and empty=1, and no tx_data_valid after reset is released.
